// File: rtl/hash_table_ctrl.sv
// Command front-end for a sketch hash table: range/capacity-checked INSERT,
// arg-max QUERY scan over the per-window count bus, and CLEAR.
module hash_table_ctrl #(
   parameter  int SKETCH_SIZE              = 16,
   parameter  int NUM_OF_BUCKETS           = 256,
   parameter  int BUCKET_SIZE              = 16,
   parameter  int MAX_WINDOWS_IN_REFERENCE = 512,
   localparam int BW = $clog2(NUM_OF_BUCKETS),
   localparam int IW = $clog2(MAX_WINDOWS_IN_REFERENCE)
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       cmd_valid,
   output logic                                       cmd_ready,
   input  logic [1:0]                                 cmd_op,
   input  logic [31:0]                                cmd_window_id,
   input  logic [SKETCH_SIZE-1:0][BW-1:0]             cmd_sketch,
   output logic                                       ht_reset,
   output logic                                       ht_is_insert,
   output logic                                       ht_is_query,
   output logic [31:0]                                ht_window_id,
   output logic [SKETCH_SIZE-1:0][BW-1:0]             ht_hashed_sketch,
   input  logic [MAX_WINDOWS_IN_REFERENCE-1:0][31:0]  ht_count_bus,
   output logic                                       rsp_valid,
   input  logic                                       rsp_ready,
   output logic [1:0]                                 rsp_status,
   output logic [IW-1:0]                              rsp_window_id,
   output logic [31:0]                                rsp_count,
   output logic                                       rsp_hit
);
   localparam int OW = $clog2(BUCKET_SIZE + 1);
   localparam int MW = $clog2(SKETCH_SIZE + 1);
   localparam int SW = OW + MW;
   localparam logic [1:0] ST_OK = 2'b00, ST_RANGE = 2'b01, ST_FULL = 2'b10;

   typedef enum logic [2:0] {IDLE, CHECK, INSERT, QUERY, SCAN, CLEAR, RESP} state_t;

   state_t                                state_q, state_d;
   logic                                  cmd_ready_q, cmd_ready_d;
   logic                                  ht_reset_q, ht_reset_d;
   logic                                  ht_is_insert_q, ht_is_insert_d;
   logic                                  ht_is_query_q, ht_is_query_d;
   logic [31:0]                           ht_window_id_q, ht_window_id_d;
   logic [SKETCH_SIZE-1:0][BW-1:0]        ht_sketch_q, ht_sketch_d;
   logic [NUM_OF_BUCKETS-1:0][OW-1:0]     occ_q, occ_d;
   logic [IW:0]                           idx_q, idx_d;
   logic                                  samp_vld_q, samp_vld_d;
   logic [31:0]                           samp_cnt_q, samp_cnt_d;
   logic [IW-1:0]                         samp_idx_q, samp_idx_d;
   logic [31:0]                           best_cnt_q, best_cnt_d;
   logic [IW-1:0]                         best_idx_q, best_idx_d;
   logic                                  rsp_valid_q, rsp_valid_d;
   logic [1:0]                            rsp_status_q, rsp_status_d;
   logic [IW-1:0]                         rsp_window_id_q, rsp_window_id_d;
   logic [31:0]                           rsp_count_q, rsp_count_d;
   logic                                  rsp_hit_q, rsp_hit_d;
   logic [NUM_OF_BUCKETS-1:0][MW-1:0]     mult;
   logic                                  full;

   // Per-bucket multiplicity of the latched sketch and the resulting overflow test
   always_comb begin
      full = 1'b0;
      for (int b = 0; b < NUM_OF_BUCKETS; b++) begin
         mult[b] = '0;
         for (int k = 0; k < SKETCH_SIZE; k++)
            if (ht_sketch_q[k] == BW'(b)) mult[b] = mult[b] + MW'(1);
         if (SW'(occ_q[b]) + SW'(mult[b]) > SW'(BUCKET_SIZE)) full = 1'b1;
      end
   end

   always_comb begin
      state_d         = state_q;
      ht_window_id_d  = ht_window_id_q;
      ht_sketch_d     = ht_sketch_q;
      occ_d           = occ_q;
      idx_d           = idx_q;
      samp_vld_d      = 1'b0;
      samp_cnt_d      = samp_cnt_q;
      samp_idx_d      = samp_idx_q;
      best_cnt_d      = best_cnt_q;
      best_idx_d      = best_idx_q;
      rsp_status_d    = rsp_status_q;
      rsp_window_id_d = rsp_window_id_q;
      rsp_count_d     = rsp_count_q;
      rsp_hit_d       = rsp_hit_q;
      case (state_q)
         IDLE: if (cmd_valid && cmd_ready_q) begin
            ht_window_id_d = cmd_window_id;
            ht_sketch_d    = cmd_sketch;
            case (cmd_op)
               2'b00:   state_d = CHECK;
               2'b01:   state_d = QUERY;
               default: state_d = CLEAR;
            endcase
         end
         CHECK: begin
            rsp_window_id_d = '0;
            rsp_count_d     = '0;
            rsp_hit_d       = 1'b0;
            if (ht_window_id_q >= 32'(MAX_WINDOWS_IN_REFERENCE)) begin
               rsp_status_d = ST_RANGE;
               state_d      = RESP;
            end else if (full) begin
               rsp_status_d = ST_FULL;
               state_d      = RESP;
            end else begin
               state_d = INSERT;
            end
         end
         INSERT: begin
            for (int b = 0; b < NUM_OF_BUCKETS; b++)
               occ_d[b] = occ_q[b] + OW'(mult[b]);
            rsp_status_d = ST_OK;
            state_d      = RESP;
         end
         QUERY: begin
            idx_d      = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
            state_d    = SCAN;
         end
         SCAN: begin
            // bus entry is registered first, compared the following cycle
            if (idx_q != (IW+1)'(MAX_WINDOWS_IN_REFERENCE)) begin
               samp_cnt_d = ht_count_bus[idx_q[IW-1:0]];
               samp_idx_d = idx_q[IW-1:0];
               samp_vld_d = 1'b1;
               idx_d      = idx_q + 1'b1;
            end
            if (samp_vld_q && samp_cnt_q > best_cnt_q) begin
               best_cnt_d = samp_cnt_q;
               best_idx_d = samp_idx_q;
            end
            if (idx_q == (IW+1)'(MAX_WINDOWS_IN_REFERENCE)) begin
               rsp_status_d    = ST_OK;
               rsp_window_id_d = best_idx_d;
               rsp_count_d     = best_cnt_d;
               rsp_hit_d       = (best_cnt_d != '0);
               state_d         = RESP;
            end
         end
         CLEAR: begin
            occ_d           = '0;
            rsp_status_d    = ST_OK;
            rsp_window_id_d = '0;
            rsp_count_d     = '0;
            rsp_hit_d       = 1'b0;
            state_d         = RESP;
         end
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cmd_ready_d    = (state_d == IDLE);
      ht_reset_d     = (state_d == CLEAR);
      ht_is_insert_d = (state_d == INSERT);
      ht_is_query_d  = (state_d == QUERY);
      rsp_valid_d    = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         cmd_ready_q     <= 1'b0;
         ht_reset_q      <= 1'b1;
         ht_is_insert_q  <= 1'b0;
         ht_is_query_q   <= 1'b0;
         ht_window_id_q  <= '0;
         ht_sketch_q     <= '0;
         occ_q           <= '0;
         idx_q           <= '0;
         samp_vld_q      <= 1'b0;
         samp_cnt_q      <= '0;
         samp_idx_q      <= '0;
         best_cnt_q      <= '0;
         best_idx_q      <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_status_q    <= '0;
         rsp_window_id_q <= '0;
         rsp_count_q     <= '0;
         rsp_hit_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cmd_ready_q     <= cmd_ready_d;
         ht_reset_q      <= ht_reset_d;
         ht_is_insert_q  <= ht_is_insert_d;
         ht_is_query_q   <= ht_is_query_d;
         ht_window_id_q  <= ht_window_id_d;
         ht_sketch_q     <= ht_sketch_d;
         occ_q           <= occ_d;
         idx_q           <= idx_d;
         samp_vld_q      <= samp_vld_d;
         samp_cnt_q      <= samp_cnt_d;
         samp_idx_q      <= samp_idx_d;
         best_cnt_q      <= best_cnt_d;
         best_idx_q      <= best_idx_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_status_q    <= rsp_status_d;
         rsp_window_id_q <= rsp_window_id_d;
         rsp_count_q     <= rsp_count_d;
         rsp_hit_q       <= rsp_hit_d;
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign ht_reset         = ht_reset_q;
   assign ht_is_insert     = ht_is_insert_q;
   assign ht_is_query      = ht_is_query_q;
   assign ht_window_id     = ht_window_id_q;
   assign ht_hashed_sketch = ht_sketch_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_status       = rsp_status_q;
   assign rsp_window_id    = rsp_window_id_q;
   assign rsp_count        = rsp_count_q;
   assign rsp_hit          = rsp_hit_q;
endmodule

// File: doc/hash_table_ctrl.md
HASH_TABLE_CTRL -- requirements
Module: hash_table_ctrl

Interface
REQ-001 Parameters SHALL be: SKETCH_SIZE default 16, sketch entries per command; NUM_OF_BUCKETS default 256, bucket count; BUCKET_SIZE default 16, bucket depth; MAX_WINDOWS_IN_REFERENCE default 512, count_bus length. BW = $clog2(NUM_OF_BUCKETS), IW = $clog2(MAX_WINDOWS_IN_REFERENCE).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command: 00 INSERT, 01 QUERY, 10 CLEAR, 11 reserved (treated as CLEAR).
- cmd_window_id  in  32  window id for INSERT.
- cmd_sketch  in  BW x SKETCH_SIZE  hashed sketch for INSERT/QUERY.
- ht_reset  out  1  active-high clear to the hash table.
- ht_is_insert, ht_is_query  out  1 each  single-cycle strobes to the hash table.
- ht_window_id  out  32  window id to the hash table.
- ht_hashed_sketch  out  BW x SKETCH_SIZE  registered sketch to the hash table.
- ht_count_bus  in  32 x MAX_WINDOWS_IN_REFERENCE  counts from the hash table.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  00 OK, 01 ERR_RANGE, 10 ERR_FULL.
- rsp_window_id  out  IW  best-matching window (QUERY), else 0.
- rsp_count  out  32  count of best window (QUERY), else 0.
- rsp_hit  out  1  QUERY found a nonzero count.

Function
REQ-003 States SHALL be IDLE, CHECK, INSERT, QUERY, SCAN, CLEAR, RESP; cmd_ready = 1 only in IDLE.
REQ-004 A command SHALL be accepted on an edge with cmd_valid && cmd_ready; it latches cmd_op, cmd_window_id and cmd_sketch into ht_window_id/ht_hashed_sketch, which stay stable until the next accept.
REQ-005 INSERT: IDLE->CHECK; in CHECK, cmd_window_id >= MAX_WINDOWS_IN_REFERENCE -> status ERR_RANGE; else any bucket b with occ[b] + (occurrences of b in sketch) > BUCKET_SIZE -> ERR_FULL; both -> ERR_RANGE; error -> RESP with no strobe.
REQ-006 INSERT without error SHALL go CHECK->INSERT, assert ht_is_insert for exactly one cycle, add each sketch entry's multiplicity to occ[], then go to RESP with OK.
REQ-007 The controller SHALL keep occ[0:NUM_OF_BUCKETS-1], each $clog2(BUCKET_SIZE+1) bits, mirroring hash-table bucket lengths; no occ entry ever exceeds BUCKET_SIZE.
REQ-008 QUERY: IDLE->QUERY, assert ht_is_query for exactly one cycle, then SCAN starting the next cycle with index 0.
REQ-009 SCAN SHALL read one ht_count_bus[idx] per cycle for idx 0..MAX_WINDOWS_IN_REFERENCE-1, keeping best = the entry with strictly greater count, so the lowest index wins ties; after the last index, go to RESP.
REQ-010 QUERY response: rsp_window_id = best index, rsp_count = best count, rsp_hit = (best count != 0); if all counts are 0 -> window_id 0, count 0, hit 0, status OK.
REQ-011 QUERY latency SHALL be accept edge + 1 strobe cycle + MAX_WINDOWS_IN_REFERENCE scan cycles; rsp_valid rises on the following edge.
REQ-012 CLEAR: IDLE->CLEAR, assert ht_reset for exactly one cycle, zero all occ[], then go to RESP with OK, window_id 0, count 0, hit 0.
REQ-013 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on the rsp_valid && rsp_ready edge, go to IDLE. A new command cannot be accepted on that same edge.
REQ-014 ht_is_insert, ht_is_query and ht_reset SHALL be registered outputs, mutually exclusive, and never asserted outside their state.
REQ-015 ht_count_bus SHALL be sampled only in SCAN; changes in other states are ignored.

Reset
REQ-016 With reset_n = 0 at an edge: state <= IDLE, occ[] <= 0, ht_reset <= 1, ht_is_insert = ht_is_query = 0, ht_window_id = 0, ht_hashed_sketch = 0, rsp_valid = 0, rsp_* = 0, cmd_ready = 0.
REQ-017 On the first edge with reset_n = 1: ht_reset <= 0 and cmd_ready <= 1. Reset asserted mid-operation aborts it and drops any pending response.

Verification
REQ-018 INSERT id 5, sketch all distinct -> one ht_is_insert pulse, rsp status 00, each touched occ = 1.
REQ-019 16 INSERTs with sketch entries all equal to bucket 3 -> the first succeeds (occ[3] = 16); the 2nd returns ERR_FULL with no strobe.
REQ-020 INSERT id 512 (default params) -> ERR_RANGE, no ht_is_insert.
REQ-021 QUERY with count_bus[7] = 4, count_bus[9] = 4, others 0 -> rsp_window_id 7, count 4, hit 1, rsp_valid 514 edges after accept.
REQ-022 QUERY with an all-zero count_bus, and rsp_ready held low 10 cycles -> rsp stays stable with window 0, count 0, hit 0; then accepted.
REQ-023 reset_n low during SCAN -> next edge shows IDLE outputs and ht_reset = 1; CLEAR -> one-cycle ht_reset and occ zeroed.
